// File: rtl/systolic_deskew_collector.sv
// Drain-side collector: realigns diagonally skewed array lanes into whole words and
// buffers them in a DEPTH-entry circular FIFO presented as a valid/ready stream.
module systolic_deskew_collector #(
  parameter int LANES = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       in_data,
  input  logic                   in_valid,
  output logic [LANES-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [LANES-1:0] aligned_data;
  logic [LANES-2:0] valid_pipe;
  logic             aligned_valid;

  // Lane j is delayed LANES-1-j cycles so every bit of a word lands in the same cycle.
  for (genvar j = 0; j < LANES - 1; j++) begin : g_lane
    logic [LANES-2-j:0] sr;
    always_ff @(posedge clk) begin
      if (reset) begin
        sr <= '0;
      end else begin
        sr[0] <= in_data[j];
        for (int k = 1; k < LANES - 1 - j; k++) sr[k] <= sr[k-1];
      end
    end
    assign aligned_data[j] = sr[LANES-2-j];
  end
  assign aligned_data[LANES-1] = in_data[LANES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_pipe <= '0;
    end else begin
      valid_pipe[0] <= in_valid;
      for (int k = 1; k < LANES - 1; k++) valid_pipe[k] <= valid_pipe[k-1];
    end
  end
  assign aligned_valid = valid_pipe[LANES-2];

  logic [LANES-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             pop;
  logic             do_write;

  assign full      = (count == FULL_COUNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the aligned word.
  assign do_write  = aligned_valid && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= aligned_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)      rd_ptr <= rd_ptr + PTR_ONE;
      if (do_write && !pop)      count <= count + COUNT_ONE;
      else if (!do_write && pop) count <= count - COUNT_ONE;
      if (aligned_valid && full && !pop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_systolic_deskew_collector.sv
// Randomized bench for systolic_deskew_collector against a queue-based word-level model.
module tb_systolic_deskew_collector;
  localparam int LANES = 8;
  localparam int DEPTH = 4;
  localparam int HIST  = 4096;

  logic             clk = 1'b0;
  logic             reset;
  logic [LANES-1:0] in_data;
  logic             in_valid;
  logic [LANES-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       count;
  logic             overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rst = -1;
  logic             hist_v [HIST];
  logic [LANES-1:0] hist_w [HIST];
  logic [LANES-1:0] mq [$];
  logic             m_ovf = 1'b0;

  systolic_deskew_collector #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // One cycle: skew the word history onto the lanes, advance the model, cross one edge.
  task automatic step(input logic rst, input logic v, input logic [LANES-1:0] w, input logic rdy);
    logic [LANES-1:0] d;
    logic [LANES-1:0] aw;
    int src;
    logic aligned, pop, full;
    if (cyc >= HIST) begin
      $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, HIST);
      $fatal(1, "cycle budget exceeded");
    end
    hist_v[cyc] = v && !rst;
    hist_w[cyc] = w;
    for (int j = 0; j < LANES; j++) begin
      src = cyc - j;
      d[j] = 1'($urandom_range(0, 1));
      if (src > last_rst) if (hist_v[src]) d[j] = hist_w[src][j];
    end
    reset = rst; in_valid = v; in_data = d; out_ready = rdy;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      last_rst = cyc;
    end else begin
      src = cyc - (LANES - 1);
      aligned = 1'b0;
      aw = '0;
      if (src > last_rst) begin
        aligned = hist_v[src];
        aw = hist_w[src];
      end
      pop  = (mq.size() != 0) && rdy;
      full = (mq.size() == DEPTH);
      if (pop) void'(mq.pop_front());
      if (aligned) begin
        if (!full || pop) mq.push_back(aw);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", out_data); end
    if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_single();
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    for (int i = 1; i < LANES; i++) begin
      // After this step the DUT is in cycle t+i+1; only at t+LANES must valid rise.
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: cycle t+%0d got %b expected 0", i, out_valid); end
      step(1'b0, 1'b0, 8'h00, 1'b0);
    end
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", out_data); end
    if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [LANES-1:0] words [4] = '{8'h01, 8'h80, 8'hFF, 8'h3C};
    logic [LANES-1:0] got [$];
    int at [$];
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, words[i], 1'b1);
    for (int i = 0; i < 14; i++) begin
      if (out_valid === 1'b1) begin got.push_back(out_data); at.push_back(cyc); end
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    checks += 3;
    if (got.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d words expected 4", got.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== words[i]) begin errors++; $display("FAIL b2b_word%0d: got %h expected %h", i, got[i], words[i]); end
      end
    end
    if (at.size() == 4 && (at[3] - at[0]) != 3) begin errors++; $display("FAIL b2b_gapless: got span %0d expected 3", at[3] - at[0]); end
    else if (at.size() != 4) begin errors++; $display("FAIL b2b_gapless: got %0d valid cycles expected 4", at.size()); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_overflow();
    logic [LANES-1:0] w [5];
    for (int i = 0; i < 5; i++) begin
      w[i] = 8'($urandom);
      step(1'b0, 1'b1, w[i], 1'b0);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    checks += 2;
    if (count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", count); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== w[i]) begin
        errors++; $display("FAIL ovf_drain%0d: got valid=%b data=%h expected 1/%h", i, out_valid, out_data, w[i]);
      end
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_lost: got valid %b expected 0", out_valid); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_reset_midflight();
    logic any_valid = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'($urandom), 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (count !== 3'd3) begin errors++; $display("FAIL midrst_pre_count: got %0d expected 3", count); end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    checks += 4;
    if (count !== 3'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", count); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow: got %b expected 0", overflow); end
    if (out_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", out_data); end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      if (out_valid !== 1'b0) any_valid = 1'b1;
    end
    checks++;
    if (any_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale: got stale word expected none"); end
  endtask

  task automatic test_full_pushpop();
    logic [LANES-1:0] w [5];
    step(1'b1, 1'b0, 8'h00, 1'b0);
    // One word in and out first so the head pointer is off zero and the refill wraps.
    step(1'b0, 1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < LANES; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      w[i] = 8'($urandom);
      step(1'b0, 1'b1, w[i], 1'b0);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (count !== 3'd4) begin errors++; $display("FAIL full_pre_count: got %0d expected 4", count); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks += 2;
    if (count !== 3'd4) begin errors++; $display("FAIL full_pushpop_count: got %0d expected 4", count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_overflow: got %b expected 0", overflow); end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== w[i]) begin
        errors++; $display("FAIL full_order%0d: got valid=%b data=%h expected 1/%h", i, out_valid, out_data, w[i]);
      end
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_stall();
    logic [LANES-1:0] w0;
    w0 = 8'($urandom);
    step(1'b0, 1'b1, w0, 1'b0);
    step(1'b0, 1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== w0 || count !== 3'd2) begin
        errors++; $display("FAIL stall_hold%0d: got valid=%b data=%h count=%0d expected 1/%h/2", i, out_valid, out_data, count, w0);
      end
      step(1'b0, 1'b0, 8'h00, 1'b0);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    logic exp_valid;
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) != 0);
      exp_valid = (mq.size() != 0);
      checks += 3;
      if (out_valid !== exp_valid) begin errors++; $display("FAIL rand_valid: cycle %0d got %b expected %b", cyc, out_valid, exp_valid); end
      if (count !== 3'(mq.size())) begin errors++; $display("FAIL rand_count: cycle %0d got %0d expected %0d", cyc, count, mq.size()); end
      if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow: cycle %0d got %b expected %b", cyc, overflow, m_ovf); end
      if (exp_valid) begin
        checks++;
        if (out_data !== mq[0]) begin errors++; $display("FAIL rand_data: cycle %0d got %h expected %h", cyc, out_data, mq[0]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < HIST; i++) begin hist_v[i] = 1'b0; hist_w[i] = '0; end
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_midflight();
    test_full_pushpop();
    test_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
